pipeline_stage_ctrl: RTL and testbench

- Sequencing controller for the CPU's pipeline register bank: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Drives each stage register's ClockEnable and its synchronous bubble/flush.
- Handles three cases:
  - load-use stalls;
  - JALR/branch redirects resolved in the MEM stage;
  - multi-cycle data-memory waits, with a timeout that halts the core.
- Sits beside the datapath. The datapath's stage registers consume its outputs.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_stage_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_stage_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, stage indices and enable/flush patterns
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;
  localparam int PC    = 0;
  localparam int IFID  = 1;
  localparam int IDEX  = 2;
  localparam int EXMEM = 3;
  localparam int MEMWB = 4;
  localparam logic [4:0] EN_ALL         = 5'b11111;
  localparam logic [4:0] EN_FREEZE      = 5'b00000;
  localparam logic [4:0] EN_BUBBLE      = EN_ALL & ~((5'b1 << PC) | (5'b1 << IFID));
  localparam logic [3:0] FLUSH_NONE     = 4'b0000;
  localparam logic [3:0] FLUSH_ALL      = 4'b1111;
  localparam logic [3:0] FLUSH_REDIRECT = 4'b0111;
  localparam logic [3:0] FLUSH_BUBBLE   = 4'b0010;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the ID sources and the EX load destination
module hazard_detect #(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_ADDR_BITS-1:0] ex_rd,
  input  logic                     ex_mem_read,
  output logic                     load_use
);
  // x0 never carries a result, so a load into it cannot create a hazard
  always_comb
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_stage_ctrl.sv
// pipeline_stage_ctrl: stage-register enable/flush sequencing for stalls, redirects and memory waits
module pipeline_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_BITS      = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Tick,
  input  logic                     halt,
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_ADDR_BITS-1:0] ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     mem_jalr_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic [4:0]               stage_en,
  output logic [3:0]               stage_flush,
  output logic                     pc_redirect,
  output logic                     timeout_err,
  output logic                     halted,
  output logic [CNT_BITS-1:0]      stall_cnt
);
  localparam int WAIT_BITS = $clog2(MEM_TIMEOUT);
  state_t               state, state_nxt;
  logic [WAIT_BITS-1:0] wait_cnt, wait_nxt;
  logic                 load_use, bubble, advance, stall_inc, set_to;
  hazard_detect #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );
  // a redirect squashes the hazarding instruction, so it never also costs a bubble
  always_comb begin
    bubble  = load_use && !mem_jalr_taken;
    advance = state == RUN ? !halt && !(mem_req && !mem_ready) : state == MEM_WAIT && mem_ready;
  end
  // state, wait counter and counter events; only takes effect on ticked edges
  always_ff @(posedge Clock)
    if (!Reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (Tick) begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (set_to) timeout_err <= 1'b1;
    end
  // next state: halt beats a memory stall, a stall beats normal sequencing
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stall_inc = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      RUN:
        if (halt) state_nxt = HALTED;
        else if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_BITS'(1);
          stall_inc = 1'b1;
        end else stall_inc = bubble;
      MEM_WAIT:
        if (mem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
          stall_inc = bubble;
        end else if (wait_cnt == WAIT_BITS'(MEM_TIMEOUT - 1)) begin
          state_nxt = HALTED;
          set_to    = 1'b1;
        end else begin
          wait_nxt  = wait_cnt + WAIT_BITS'(1);
          stall_inc = 1'b1;
        end
      default: state_nxt = state;
    endcase
  end
  // stage controls: reset flushes everything, frozen or untick'd cycles hold everything
  always_comb begin
    stage_en    = !Reset ? EN_FREEZE : !(Tick && advance) ? EN_FREEZE :
                  mem_jalr_taken ? EN_ALL : load_use ? EN_BUBBLE : EN_ALL;
    stage_flush = !Reset ? FLUSH_ALL : !(Tick && advance) ? FLUSH_NONE :
                  mem_jalr_taken ? FLUSH_REDIRECT : load_use ? FLUSH_BUBBLE : FLUSH_NONE;
    pc_redirect = Reset && Tick && advance && mem_jalr_taken;
    halted      = state == HALTED;
  end
endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// tb_pipeline_stage_ctrl: scoreboard bench for the pipeline stage controller
module tb_pipeline_stage_ctrl;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Tick = 1'b1;
  logic       halt = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       mem_jalr_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic [4:0] stage_en;
  logic [3:0] stage_flush;
  logic       pc_redirect, timeout_err, halted;
  logic [3:0] stall_cnt;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [4:0] en;
    logic [3:0] fl;
    logic       rd;
    logic       hl;
    logic       to;
    logic [3:0] sc;
  } exp_t;
  exp_t q[$];
  int         m_state = 0;
  int         m_wait = 0;
  logic [3:0] m_stall = '0;
  logic       m_to = 1'b0;

  pipeline_stage_ctrl #(.REG_ADDR_BITS(5), .MEM_TIMEOUT(4), .CNT_BITS(4)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Tick           (Tick),
    .halt           (halt),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .mem_jalr_taken (mem_jalr_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stage_en       (stage_en),
    .stage_flush    (stage_flush),
    .pc_redirect    (pc_redirect),
    .timeout_err    (timeout_err),
    .halted         (halted),
    .stall_cnt      (stall_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hazard();
    return ex_mem_read && ex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic bump();
    if (m_stall != 4'hf) m_stall++;
  endtask

  task automatic idle();
    halt = 0; ex_mem_read = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    mem_jalr_taken = 0; mem_req = 0; mem_ready = 0; Tick = 1;
  endtask

  // one clock: push the expectation, compare at negedge, then advance the model
  task automatic cycle();
    exp_t e;
    logic go;
    e.hl = m_state == 2; e.to = m_to; e.sc = m_stall;
    e.en = 5'b00000; e.fl = 4'b0000; e.rd = 1'b0;
    go = Tick && ((m_state == 0 && !halt && !(mem_req && !mem_ready)) || (m_state == 1 && mem_ready));
    if (!Reset) e.fl = 4'b1111;
    else if (go) begin
      if (mem_jalr_taken) begin e.en = 5'b11111; e.fl = 4'b0111; e.rd = 1'b1; end
      else if (hazard()) begin e.en = 5'b11100; e.fl = 4'b0010; end
      else e.en = 5'b11111;
    end
    q.push_back(e);
    @(negedge Clock);
    if (q.size() == 0) check("sb_empty", 0, 1);
    else begin
      e = q.pop_front();
      check("stage_en", 32'(stage_en), 32'(e.en));
      check("stage_flush", 32'(stage_flush), 32'(e.fl));
      check("pc_redirect", 32'(pc_redirect), 32'(e.rd));
      check("halted", 32'(halted), 32'(e.hl));
      check("timeout_err", 32'(timeout_err), 32'(e.to));
      check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
    end
    @(posedge Clock);
    if (!Reset) begin m_state = 0; m_wait = 0; m_stall = '0; m_to = 0; end
    else if (Tick) begin
      if (m_state == 0) begin
        if (halt) m_state = 2;
        else if (mem_req && !mem_ready) begin m_state = 1; m_wait = 1; bump(); end
        else if (hazard() && !mem_jalr_taken) bump();
      end else if (m_state == 1) begin
        if (mem_ready) begin m_state = 0; m_wait = 0; if (hazard() && !mem_jalr_taken) bump(); end
        else if (m_wait == 3) begin m_state = 2; m_to = 1; end
        else begin m_wait++; bump(); end
      end
    end
    #1;
  endtask

  task automatic load_use_rs2();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1; id_rs1 = 5'd0; id_use_rs1 = 0;
  endtask

  initial begin
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) cycle();
    check("rst_flush", 32'(stage_flush), 32'h0f);
    Reset = 1;
    #1 check("first_en", 32'(stage_en), 32'h1f);
    cycle(); cycle();
    load_use_rs2();
    #1 check("lu_en", 32'(stage_en), 32'h1c);
    cycle();
    check("lu_cnt", 32'(stall_cnt), 1);
    idle(); cycle();
    load_use_rs2(); mem_jalr_taken = 1;
    #1 check("redir_flush", 32'(stage_flush), 32'h7);
    cycle();
    check("redir_cnt", 32'(stall_cnt), 1);
    idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; cycle();
    idle(); load_use_rs2(); Tick = 0; cycle(); cycle();
    check("tick0_cnt", 32'(stall_cnt), 1);
    Tick = 1; cycle();
    check("tick1_cnt", 32'(stall_cnt), 2);
    idle(); mem_ready = 1; cycle();
    idle(); mem_req = 1; cycle(); cycle(); cycle();
    mem_ready = 1; cycle();
    check("wait_cnt", 32'(stall_cnt), 5);
    idle(); id_use_rs1 = 1; id_rs1 = 5'd7; ex_rd = 5'd7; ex_mem_read = 1;
    for (int i = 0; i < 14; i++) cycle();
    check("sat_cnt", 32'(stall_cnt), 15);
    idle(); mem_req = 1; cycle(); cycle(); Reset = 0; cycle();
    Reset = 1; idle(); cycle();
    check("rst_mid", 32'(stall_cnt), 0);
    mem_req = 1;
    for (int i = 0; i < 6; i++) cycle();
    check("to_flag", 32'(timeout_err), 1);
    check("to_halt", 32'(halted), 1);
    Reset = 0; idle(); cycle(); Reset = 1;
    halt = 1; cycle(); cycle(); halt = 0; cycle(); cycle();
    check("halt_stay", 32'(halted), 1);
    Reset = 0; cycle(); Reset = 1;
    for (int i = 0; i < 400; i++) begin
      Reset = $urandom_range(0, 19) != 0;
      Tick = $urandom_range(0, 5) != 0;
      halt = $urandom_range(0, 40) == 0;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_jalr_taken = $urandom_range(0, 4) == 0;
      mem_req = 1'($urandom); mem_ready = 1'($urandom);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
